cascade_mod_counter: RTL
========================

Name: cascade_mod_counter

Overview:
Parametrised multi-digit modulo counter. Generalises the single-digit mod-10 sequencer to DIGITS cascaded digits with configurable modulus, up/down count, enable, synchronous clear and parallel load. Drives display digit buses and a terminal-count strobe for timers, frequency dividers and event tallies in the lab designs. Each digit feeds a seven-segment decoder downstream.

Parameters:
DIGITS, 4, number of cascaded digits (1..8)
MODULUS, 10, per-digit modulus (2..2**DW)
DW, 4, bits per digit

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high; all digits to 0
Clear  in  1  synchronous clear to 0
Load  in  1  synchronous parallel load of LoadVal
LoadVal  in  DIGITS*DW  load value, digit 0 in [DW-1:0]
En  in  1  count enable, one step per enabled clock
Up  in  1  1 = count up, 0 = count down
D  out  DIGITS*DW  current count, digit 0 (least significant) in [DW-1:0]
Zero  out  1  combinational; 1 when every digit is 0
Wrap  out  1  registered one-cycle strobe on full-counter rollover

Behaviour:
- Reset (async): every digit = 0, Wrap = 0; Zero = 1 immediately.
- Per-clock priority: Clear > Load > En > hold.
- Clear: all digits to 0; Wrap = 0 next cycle.
- Load: digit i takes LoadVal[i]; any field >= MODULUS loads as 0 for that digit only. Wrap = 0 next cycle.
- En with Up=1:
  - digit 0 increments;
  - digit i>0 increments only when digits 0..i-1 are all MODULUS-1 (ripple carry, same cycle);
  - a digit at MODULUS-1 that increments goes to 0.
- En with Up=0:
  - digit 0 decrements;
  - digit i>0 decrements only when digits 0..i-1 are all 0 (borrow);
  - a digit at 0 that decrements goes to MODULUS-1.
- Wrap = 1 for exactly the one cycle after an enabled step in which all digits roll over:
  - up: all digits MODULUS-1 -> all 0;
  - down: all 0 -> all MODULUS-1;
  - otherwise Wrap = 0.
- Latency: D updates on the clock edge after the controlling input is sampled. Zero follows D combinationally. Wrap is valid in the same cycle as the new D.
- En=0 with no Clear/Load: D holds, Wrap = 0.
- Up changed mid-count: takes effect on the next enabled edge; no extra step, no skipped value.
- Illegal digit (>= MODULUS, reachable only by upset): forced to 0 on the next edge regardless of En. Its carry/borrow is treated as 0 that cycle.
- Reset asserted mid-count: immediate return to 0. First enabled edge after release gives count 1 (up) or all MODULUS-1 (down).
- DIGITS=1, MODULUS=10, Up=1, En=1: D sequence is 0..9,0. Zero is high when D=0, matching the legacy single-digit Q.

Decomposition:
- Shared package counter_pkg:
  - default DIGITS/MODULUS/DW constants;
  - direction enum (CNT_DOWN=0, CNT_UP=1);
  - function clamp_digit(value, MODULUS).
- Sub-module mod_digit: one digit register with inputs:
  - step (enable && all-lower-digits-terminal);
  - Up, Clear, Load, load digit.
  - Outputs: digit value, at_max, at_zero.
- Top level: generate loop over DIGITS, carry/borrow AND-chain, Wrap register, Zero reduction.

Test Plan:
1. DIGITS=2, MODULUS=10. Reset, En=1, Up=1 for 100 clocks -> D steps 00..99, then 00 on clock 100; Wrap high exactly that one cycle; Zero high at 00 only.
2. Load LoadVal=0x09, En=1, Up=1 one clock -> D=0x10 (carry into digit 1); Wrap=0.
3. Reset, Up=0, En=1 one clock -> D=0x99, Wrap=1 for one cycle; next clock D=0x98, Wrap=0.
4. Clear and Load both high with D=0x57 and LoadVal=0x33 -> D=0x00. Load alone with LoadVal=0xA3 -> D=0x03 (digit 1 clamped to 0).
5. D=0x45, En toggled 1,0,0,1 with Up=1 -> D sequence 0x46, 0x46, 0x46, 0x47. Up flipped to 0 on the last step -> next enabled edge D=0x46.
6. Assert Reset asynchronously between edges while D=0x72 -> D=0x00 and Zero=1 before the next edge. First enabled edge after release -> D=0x01.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the cascaded modulo counter.
// Default geometry matches a four-digit decimal display.
package counter_pkg;

    localparam int DEF_DIGITS  = 4;
    localparam int DEF_MODULUS = 10;
    localparam int DEF_DW      = 4;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    function automatic logic [31:0] clamp_digit(
        input logic [31:0] value,
        input int          modulus
    );
        return (value >= 32'(modulus)) ? 32'd0 : value;
    endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-MODULUS digit of the cascade.
// Out-of-range values self-heal to 0 and never propagate a carry.
module mod_digit
    import counter_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          step,
    input  cnt_dir_e      dir,
    output logic [DW-1:0] q,
    output logic          at_max,
    output logic          at_zero
);

    localparam logic [DW-1:0] MAXV = DW'(MODULUS - 1);
    localparam logic [DW:0]   MODV = (DW+1)'(MODULUS);

    logic [DW-1:0] q_nxt;
    logic [DW-1:0] load_clamped;
    logic          legal;

    assign legal        = {1'b0, q} < MODV;
    assign at_max       = (q == MAXV);
    assign at_zero      = (q == '0);
    assign load_clamped = DW'(clamp_digit(32'(load_val), MODULUS));

    always_comb begin
        q_nxt = q;
        if (clear) begin
            q_nxt = '0;
        end else if (load) begin
            q_nxt = load_clamped;
        end else if (!legal) begin
            q_nxt = '0;
        end else if (step) begin
            if (dir == CNT_UP) begin
                q_nxt = at_max ? '0 : q + 1'b1;
            end else begin
                q_nxt = at_zero ? MAXV : q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/cascade_mod_counter.sv
// Multi-digit up/down modulo counter with ripple carry/borrow,
// full-rollover strobe and all-zero flag.
module cascade_mod_counter
    import counter_pkg::*;
#(
    parameter int DIGITS  = DEF_DIGITS,
    parameter int MODULUS = DEF_MODULUS,
    parameter int DW      = DEF_DW
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Clear,
    input  logic                 Load,
    input  logic [DIGITS*DW-1:0] LoadVal,
    input  logic                 En,
    input  logic                 Up,
    output logic [DIGITS*DW-1:0] D,
    output logic                 Zero,
    output logic                 Wrap
);

    cnt_dir_e          dir;
    logic [DIGITS:0]   carry;
    logic [DIGITS:0]   borrow;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS-1:0] step;
    logic              wrap_nxt;

    assign dir       = cnt_dir_e'(Up);
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign carry[i+1]  = carry[i] & at_max[i];
        assign borrow[i+1] = borrow[i] & at_zero[i];
        assign step[i]     = En & ((dir == CNT_UP) ? carry[i] : borrow[i]);

        mod_digit #(
            .DW      (DW),
            .MODULUS (MODULUS)
        ) u_digit (
            .Clk      (Clk),
            .Reset    (Reset),
            .clear    (Clear),
            .load     (Load),
            .load_val (LoadVal[i*DW +: DW]),
            .step     (step[i]),
            .dir      (dir),
            .q        (D[i*DW +: DW]),
            .at_max   (at_max[i]),
            .at_zero  (at_zero[i])
        );
    end

    // Every digit terminal means every digit rolls on this step
    assign wrap_nxt = En && !Clear && !Load &&
                      ((dir == CNT_UP) ? carry[DIGITS] : borrow[DIGITS]);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Wrap <= 1'b0;
        end else begin
            Wrap <= wrap_nxt;
        end
    end

    assign Zero = (D == '0);

endmodule
